// File: rtl/ram_bist.sv
// March-style BIST controller for a 2^AW x DW RAM: writes/reads a seeded pattern, then its inverse.
// Optional first-fail logging is enabled by defining RAM_BIST_ERRLOG_EN.
module ram_bist #(
  parameter int AW     = 8,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] seed,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW+1:0] err_cnt,
  output logic [AW-1:0] fail_addr,
  output logic [DW-1:0] fail_data,
  output logic          w_sig,
  output logic [AW-1:0] add_w,
  output logic [DW-1:0] din,
  output logic [AW-1:0] add_r,
  input  logic [DW-1:0] dout
);

  localparam logic [AW-1:0] ADDR_MAX = '1;

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

  state_t        state, state_d;
  logic [DW-1:0] seed_q;
  logic          rd_vld, rd_vld_d;
  logic [1:0]    drain, drain_d;
  logic          w_sig_d, busy_d, done_d, pass_d;
  logic [AW-1:0] add_w_d, add_r_d;
  logic [DW-1:0] din_d;
  logic          start_acc, flush;

  // Read-compare pipeline: valid and expected data travel alongside the RAM latency.
  logic [RD_LAT-1:0] pv;
  logic [DW-1:0]     pe [RD_LAT];
  logic              hit;
  logic [AW+1:0]     err_nxt;

  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] addr,
                                            input logic          phase,
                                            input logic [DW-1:0] sd);
    logic [DW-1:0] p;
    p = DW'(addr) ^ sd;
    return phase ? ~p : p;
  endfunction

  assign flush   = abort && (state != IDLE);
  assign hit     = pv[RD_LAT-1] && (dout != pe[RD_LAT-1]) && !flush;
  assign err_nxt = err_cnt + {{(AW+1){1'b0}}, hit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state;
    w_sig_d   = 1'b0;
    add_w_d   = '0;
    din_d     = '0;
    add_r_d   = add_r;
    rd_vld_d  = 1'b0;
    drain_d   = drain;
    done_d    = 1'b0;
    pass_d    = pass;
    start_acc = 1'b0;

    case (state)
      IDLE: begin
        add_r_d = '0;
        drain_d = '0;
        if (start && !abort) begin
          state_d   = WR0;
          start_acc = 1'b1;
          w_sig_d   = 1'b1;
          din_d     = pattern('0, 1'b0, seed);
          pass_d    = 1'b0;
        end
      end

      WR0, WR1: begin
        if (add_w == ADDR_MAX) begin
          state_d  = (state == WR0) ? RD0 : RD1;
          rd_vld_d = 1'b1;
          add_r_d  = '0;
        end else begin
          w_sig_d = 1'b1;
          add_w_d = add_w + 1'b1;
          din_d   = pattern(add_w + 1'b1, state == WR1, seed_q);
        end
      end

      RD0, RD1: begin
        if (rd_vld) begin
          if (add_r == ADDR_MAX) begin
            drain_d = 2'd1;
          end else begin
            rd_vld_d = 1'b1;
            add_r_d  = add_r + 1'b1;
          end
        end else if (drain == 2'(RD_LAT)) begin
          // Last read has been compared in this cycle; move on.
          drain_d = '0;
          add_r_d = '0;
          if (state == RD0) begin
            state_d = WR1;
            w_sig_d = 1'b1;
            din_d   = pattern('0, 1'b1, seed_q);
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
            pass_d  = (err_nxt == '0);
          end
        end else begin
          drain_d = drain + 2'd1;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d  = IDLE;
      w_sig_d  = 1'b0;
      add_w_d  = '0;
      din_d    = '0;
      add_r_d  = '0;
      rd_vld_d = 1'b0;
      drain_d  = '0;
      done_d   = 1'b0;
      pass_d   = 1'b0;
    end

    busy_d = (state_d == WR0) || (state_d == RD0) || (state_d == WR1) || (state_d == RD1);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      drain   <= '0;
      seed_q  <= '0;
      w_sig   <= 1'b0;
      add_w   <= '0;
      din     <= '0;
      add_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      rd_vld <= rd_vld_d;
      drain  <= drain_d;
      w_sig  <= w_sig_d;
      add_w  <= add_w_d;
      din    <= din_d;
      add_r  <= add_r_d;
      busy   <= busy_d;
      done   <= done_d;
      pass   <= pass_d;
      if (start_acc) begin
        seed_q  <= seed;
        err_cnt <= '0;
      end else begin
        err_cnt <= err_nxt;
      end
    end
  end

  // NOTE: the pipeline arrays are only RD_LAT deep, so they share the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv <= '0;
      for (int k = 0; k < RD_LAT; k++) pe[k] <= '0;
    end else begin
      pv[0] <= rd_vld && !flush;
      pe[0] <= pattern(add_r, state == RD1, seed_q);
      for (int k = 1; k < RD_LAT; k++) begin
        pv[k] <= pv[k-1] && !flush;
        pe[k] <= pe[k-1];
      end
    end
  end

`ifdef RAM_BIST_ERRLOG_EN
  logic [AW-1:0] pa [RD_LAT];
  logic          fail_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LAT; k++) pa[k] <= '0;
      fail_seen <= 1'b0;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      pa[0] <= add_r;
      for (int k = 1; k < RD_LAT; k++) pa[k] <= pa[k-1];
      if (start_acc) begin
        fail_seen <= 1'b0;
        fail_addr <= '0;
        fail_data <= '0;
      end else if (hit && !fail_seen) begin
        fail_seen <= 1'b1;
        fail_addr <= pa[RD_LAT-1];
        fail_data <= dout;
      end
    end
  end
`else
  assign fail_addr = '0;
  assign fail_data = '0;
`endif

endmodule

// File: doc/ram_bist.md
# ram_bist

Synthesizable built-in self-test controller that drives the write and read ports of the 256 x 8 dual-address RAM (`ram`) and checks its read data. It writes and reads back a seeded pattern and its inverse across every address, counting mismatches and reporting pass/fail. It sits between system control logic and the RAM, replacing bench-only write/read/compare tasks with hardware.

## Interface
- `AW`, 8: address width; depth is 2^AW.
- `DW`, 8: data width.
- `RD_LAT`, 1: RAM read latency in clocks, 1 or 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a test when idle; ignored while `busy`.
- `abort` in 1: synchronous cancel of a running test.
- `seed` in DW: pattern seed, sampled on accepted `start`.
- `busy` out 1: test in progress.
- `done` out 1: one-cycle pulse when a test completes (not on abort).
- `pass` out 1: 1 when the last completed test had `err_cnt`=0.
- `err_cnt` out AW+2: mismatch count, covering up to 2*2^AW.
- `fail_addr` out AW: address of the first mismatch.
- `fail_data` out DW: data read at the first mismatch.
- `w_sig` out 1: RAM write enable.
- `add_w` out AW: RAM write address.
- `din` out DW: RAM write data.
- `add_r` out AW: RAM read address.
- `dout` in DW: RAM read data.

## Operation
- States: IDLE, WR0, RD0, WR1, RD1, DONE.
- Expected data:
  - Phase 0: `add ^ seed_q`.
  - Phase 1: `~(add ^ seed_q)`.
- IDLE + `start`=1: latch `seed`, clear `err_cnt`, `pass`, `fail_*`, and the first-fail flag, then go to WR0.
- WR0/WR1:
  - `w_sig`=1; `add_w` steps 0 to 2^AW−1, one per cycle; `din` holds the phase pattern.
  - After the last address, go to RD0 or RD1.
- RD0/RD1:
  - `add_r` steps 0 to 2^AW−1, one per cycle.
  - A RD_LAT-deep pipeline carries valid, address and expected data.
  - After the last address, the state holds RD_LAT drain cycles, then goes to WR1 or DONE.
- Compare: when the pipeline output is valid and `dout` ≠ expected, increment `err_cnt`. On the first mismatch only, capture `fail_addr` and `fail_data`=`dout`.
- DONE (one cycle): `done`=1, `pass`=(`err_cnt`==0), then IDLE.
- `w_sig` and reads never overlap. In IDLE, `w_sig`=0 and `add_w`/`add_r`/`din` hold 0.
- `abort`=1 in any non-IDLE state:
  - Next state IDLE; `w_sig`=0 immediately; pipeline flushed.
  - `pass`=0; no `done`; `err_cnt` frozen.
- Simultaneous `start` and `abort` in IDLE: `abort` wins, so the test does not start.
- `rst_n` low at any time:
  - All outputs and state go to 0 (IDLE) asynchronously, including `w_sig`.
  - A write in flight is abandoned.
- Address counters never wrap inside a phase. Phase transitions reset the counter to 0.

## Timing
- All outputs are registered.
- The edge that samples `start` puts WR0 in effect: `w_sig`=1, `add_w`=0, `din`=`seed`.
- `dout` for `add_r` driven in cycle n is compared in cycle n+RD_LAT.
- Busy duration: `busy` is high for exactly 4*2^AW + 2*RD_LAT cycles (1026 at defaults) before DONE.
- `done`, `pass` and the final `err_cnt` are valid in the same cycle, with `busy` low.
- Reset values: every output 0.

## Configuration
- `RAM_BIST_ERRLOG_EN`:
  - Defined: first-fail capture into `fail_addr` and `fail_data` as described above.
  - Undefined: no capture registers; `fail_addr` and `fail_data` are tied 0. `err_cnt` and `pass` are unaffected.

## Test plan
- Good RAM model, RD_LAT=1, `seed`=0xA5, `start` pulse → `busy` high 1026 cycles, then `done` pulse, `pass`=1, `err_cnt`=0.
- Model with bit 0 stuck at 1 at address 0x3C, `seed`=0x00 → `pass`=0, `err_cnt`=1, `fail_addr`=0x3C, `fail_data`=0x3D (with `RAM_BIST_ERRLOG_EN`).
- Model ignoring address bit 7, `seed`=0x00 → `err_cnt`=256, `fail_addr`=0x00, `fail_data`=0x80, `pass`=0.
- `start` pulsed again mid-WR0 → ignored, run length unchanged. `abort` at cycle 600 (WR1) → IDLE next cycle, `w_sig`=0, no `done`, `pass`=0.
- `rst_n` low during RD0 → all outputs 0 without a clock edge. After release, `start` → full passing run.
- RD_LAT=2 with a 2-cycle model, `seed`=0xFF → `busy` 1028 cycles, `pass`=1, `err_cnt`=0.
